pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: DIV_LAT, default 8, EX-stage cycles a div/rem occupies (legal 2..15).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-004 IR  in  32  instruction in ID; rs=IR[25:21], rt=IR[20:16], opcode=IR[31:26].
REQ-005 DX_MemRead, DX_RegWrite, DX_div  in  1 each  ID/EX control; DX_div=1 for funct 26/27.
REQ-006 DX_RD, DX_RS, DX_RT  in  5 each  ID/EX register numbers.
REQ-007 XM_RegWrite in 1, XM_RD in 5, MW_RegWrite in 1, MW_RD in 5: later-stage writeback info.
REQ-008 branch_taken  in  1  resolved taken branch from EX/MEM; jump  in  1  jump in ID/EX.
REQ-009 PC_write, IF_ID_write  out  1 each  pipeline-register enables (0 = hold).
REQ-010 IF_flush, DX_flush  out  1 each  insert bubble into IF/ID or ID/EX.
REQ-011 fwdA, fwdB  out  2 each  EX operand select: 00 regfile, 10 XM_ALUout, 01 MW writeback.
REQ-012 busy  out  1  high in any non-RUN state; stall_cnt  out  32  total stalled cycles.

Function
REQ-013 States SHALL be RUN, LU_STALL, DIV_BUSY, RAW_STALL; encoding 2 bits.
REQ-014 Load-use: in RUN, DX_MemRead=1, DX_RD!=0, DX_RD equals rs or rt (rt only for opcodes 0, 4, 5, 43) -> LU_STALL for exactly one cycle, then RUN.
REQ-015 DIV_BUSY: in RUN with DX_div=1 -> DIV_BUSY; 4-bit counter loads DIV_LAT-1, decrements each cycle; returns to RUN the cycle after counter reaches 1.
REQ-016 In LU_STALL, DIV_BUSY, RAW_STALL: PC_write=0, IF_ID_write=0; LU_STALL/RAW_STALL also DX_flush=1; DIV_BUSY holds ID/EX (DX_flush=0).
REQ-017 branch_taken=1: IF_flush=1, DX_flush=1, PC_write=1 same cycle, next state RUN from any state (aborts DIV_BUSY, counter cleared).
REQ-018 jump=1 with branch_taken=0: IF_flush=1 for one cycle; has no effect while in DIV_BUSY until exit.
REQ-019 Priority: reset > branch_taken > DIV_BUSY > load-use/RAW > jump.
REQ-020 Forwarding (macro defined): fwdA=10 if XM_RegWrite and XM_RD!=0 and XM_RD==DX_RS; else 01 if MW_RegWrite, MW_RD!=0, MW_RD==DX_RS; else 00; fwdB identical on DX_RT; combinational.
REQ-021 Register 0 SHALL never match for any hazard or forward.
REQ-022 stall_cnt increments by 1 each cycle PC_write=0; wraps 0xFFFFFFFF -> 0.
REQ-023 All outputs except fwdA/fwdB SHALL derive from registered state plus current inputs; no combinational loop through PC_write.

Reset
REQ-024 rst=0: state RUN, counter 0, stall_cnt 0, busy 0; PC_write=1, IF_ID_write=1, flushes 0, fwd 00.
REQ-025 Reset mid-DIV_BUSY or mid-stall SHALL abandon it; first cycle after release is RUN.

Configuration
REQ-026 Macro HAZ_FORWARD_EN: defined -> REQ-020 forwarding, RAW_STALL unused.
REQ-027 Undefined -> fwdA=fwdB=00 constant; in RUN, ID rs/rt matching DX_RD or XM_RD (RegWrite=1, RD!=0) enters RAW_STALL, held until no match, then RUN.

Structure
REQ-028 Shared package pipe_pkg: state enum, opcode constants (R=0, LW=35, SW=43, BEQ=4, BNE=5, J=2), fwd select constants.
REQ-029 One sub-module: haz_fwd_unit (combinational forwarding compare); FSM and counters stay in top.

Verification
REQ-030 lw $4 then add $5,$4,$1 -> one cycle PC_write=0, DX_flush=1, stall_cnt 0->1.
REQ-031 div with DIV_LAT=8 -> busy high 7 cycles, PC_write low 7 cycles, then RUN.
REQ-032 branch_taken=1 on 3rd DIV_BUSY cycle -> IF_flush=DX_flush=1 same cycle, RUN next cycle.
REQ-033 HAZ_FORWARD_EN: XM_RD=MW_RD=DX_RS=3, both RegWrite=1 -> fwdA=10; XM_RD=0, MW_RD=3 -> fwdA=01.
REQ-034 Without HAZ_FORWARD_EN: add $6,$2,$1 then sub $7,$6,$1 -> RAW_STALL 2 cycles, fwd 00.
REQ-035 rst=0 asserted mid-LU_STALL -> outputs at reset values asynchronously, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by pipe_hazard_ctrl and haz_fwd_unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_DIV_BUSY  = 2'd2,
    ST_RAW_STALL = 2'd3
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MW = 2'b01;
  localparam logic [1:0] FWD_XM = 2'b10;

  // rt is a source operand only for R-type, branches and stores
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/haz_fwd_unit.sv
// Combinational two-source compare against a near (a) and far (b) writer.
// Near writer wins; register 0 never matches.
module haz_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_a_wr,
  input  logic [4:0] i_a_rd,
  input  logic       i_b_wr,
  input  logic [4:0] i_b_rd,
  output logic [1:0] o_sel_a,
  output logic [1:0] o_sel_b
);

  function automatic logic [1:0] pick(input logic [4:0] src,
                                      input logic a_wr, input logic [4:0] a_rd,
                                      input logic b_wr, input logic [4:0] b_rd);
    if (src == 5'd0)               return FWD_RF;
    else if (a_wr && (a_rd == src)) return FWD_XM;
    else if (b_wr && (b_rd == src)) return FWD_MW;
    else                           return FWD_RF;
  endfunction

  assign o_sel_a = pick(i_rs, i_a_wr, i_a_rd, i_b_wr, i_b_rd);
  assign o_sel_b = pick(i_rt, i_a_wr, i_a_rd, i_b_wr, i_b_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, divider and RAW stalls plus branch/jump flushes.
// Macro HAZ_FORWARD_EN: forward EX operands instead of stalling on RAW hazards.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic        DX_MemRead,
  input  logic        DX_RegWrite,
  input  logic        DX_div,
  input  logic [4:0]  DX_RD,
  input  logic [4:0]  DX_RS,
  input  logic [4:0]  DX_RT,
  input  logic        XM_RegWrite,
  input  logic [4:0]  XM_RD,
  input  logic        MW_RegWrite,
  input  logic [4:0]  MW_RD,
  input  logic        branch_taken,
  input  logic        jump,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_flush,
  output logic        DX_flush,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        busy,
  output logic [31:0] stall_cnt
);
  // state        | meaning
  // RUN          | normal issue
  // LU_STALL     | one bubble after a load feeding the ID instruction
  // DIV_BUSY     | divider occupies EX, ID/EX held, counter running
  // RAW_STALL    | bubbles until no in-flight writer matches ID sources

  localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_div_cnt, w_div_cnt_nxt;
  logic [31:0] r_stall_cnt;
  logic [4:0]  w_rs, w_rt;
  logic [5:0]  w_op;
  logic        w_rt_used, w_lu_hit, w_raw_hit, w_jump_flush;
  logic [1:0]  w_sel_a, w_sel_b;
  logic        w_unused;

  assign w_op      = IR[31:26];
  assign w_rs      = IR[25:21];
  assign w_rt      = IR[20:16];
  assign w_rt_used = uses_rt(w_op);
  assign w_lu_hit  = DX_MemRead && (DX_RD != 5'd0) &&
                     ((DX_RD == w_rs) || (w_rt_used && (DX_RD == w_rt)));

`ifdef HAZ_FORWARD_EN
  haz_fwd_unit u_fwd (
    .i_rs(DX_RS), .i_rt(DX_RT),
    .i_a_wr(XM_RegWrite), .i_a_rd(XM_RD),
    .i_b_wr(MW_RegWrite), .i_b_rd(MW_RD),
    .o_sel_a(w_sel_a), .o_sel_b(w_sel_b)
  );
  assign w_raw_hit = 1'b0;
  assign fwdA      = rst ? w_sel_a : FWD_RF;
  assign fwdB      = rst ? w_sel_b : FWD_RF;
  assign w_unused  = ^{IR[15:0], DX_RegWrite};
`else
  // Same comparator reused one stage earlier: ID sources against EX and MEM writers
  haz_fwd_unit u_fwd (
    .i_rs(w_rs), .i_rt(w_rt),
    .i_a_wr(DX_RegWrite), .i_a_rd(DX_RD),
    .i_b_wr(XM_RegWrite), .i_b_rd(XM_RD),
    .o_sel_a(w_sel_a), .o_sel_b(w_sel_b)
  );
  assign w_raw_hit = (w_sel_a != FWD_RF) || (w_rt_used && (w_sel_b != FWD_RF));
  assign fwdA      = FWD_RF;
  assign fwdB      = FWD_RF;
  assign w_unused  = ^{IR[15:0], DX_RS, DX_RT, MW_RegWrite, MW_RD};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_div_cnt   <= 4'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (!PC_write) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_jump_flush  = 1'b0;
    if (branch_taken) begin
      w_state_nxt   = ST_RUN;
      w_div_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (DX_div) begin
            w_state_nxt   = ST_DIV_BUSY;
            w_div_cnt_nxt = DIV_LOAD;
          end else if (w_lu_hit) begin
            w_state_nxt = ST_LU_STALL;
          end else if (w_raw_hit) begin
            w_state_nxt = ST_RAW_STALL;
          end else begin
            w_jump_flush = jump;
          end
        end
        ST_LU_STALL: w_state_nxt = ST_RUN;
        ST_DIV_BUSY: begin
          w_div_cnt_nxt = r_div_cnt - 4'd1;
          if (r_div_cnt <= 4'd1) begin
            w_state_nxt   = ST_RUN;
            w_div_cnt_nxt = 4'd0;
          end
        end
        ST_RAW_STALL: if (!w_raw_hit) w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign PC_write    = (r_state == ST_RUN) || branch_taken;
  assign IF_ID_write = (r_state == ST_RUN) || branch_taken;
  assign IF_flush    = rst && (branch_taken || w_jump_flush);
  assign DX_flush    = rst && (branch_taken || (r_state == ST_LU_STALL) ||
                               (r_state == ST_RAW_STALL));
  assign busy        = (r_state != ST_RUN);
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences,
// and randomized cycles against a behavioural model (honours HAZ_FORWARD_EN).
module tb_pipe_hazard_ctrl;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif
  localparam int DLAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic        DX_MemRead, DX_RegWrite, DX_div;
  logic [4:0]  DX_RD, DX_RS, DX_RT;
  logic        XM_RegWrite, MW_RegWrite;
  logic [4:0]  XM_RD, MW_RD;
  logic        branch_taken, jump;
  logic        PC_write, IF_ID_write, IF_flush, DX_flush, busy;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] stall_cnt;

  int n_chk = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.DIV_LAT(DLAT)) dut (
    .clk(clk), .rst(rst), .IR(IR),
    .DX_MemRead(DX_MemRead), .DX_RegWrite(DX_RegWrite), .DX_div(DX_div),
    .DX_RD(DX_RD), .DX_RS(DX_RS), .DX_RT(DX_RT),
    .XM_RegWrite(XM_RegWrite), .XM_RD(XM_RD),
    .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD),
    .branch_taken(branch_taken), .jump(jump),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .IF_flush(IF_flush), .DX_flush(DX_flush),
    .fwdA(fwdA), .fwdB(fwdB), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        memrd, dxwr, div;
    logic [4:0]  dxrd, dxrs, dxrt;
    logic        xmwr;
    logic [4:0]  xmrd;
    logic        mwwr;
    logic [4:0]  mwrd;
    logic        br, jmp;
    logic        e_iff, e_dxf;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0123};
  endfunction

  task automatic clear_inputs();
    IR = 32'h0; DX_MemRead = 0; DX_RegWrite = 0; DX_div = 0;
    DX_RD = 0; DX_RS = 0; DX_RT = 0; XM_RegWrite = 0; XM_RD = 0;
    MW_RegWrite = 0; MW_RD = 0; branch_taken = 0; jump = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_div_left;
  bit          m_lu, m_raw;
  int unsigned m_stall;

  function automatic bit reads(input logic [4:0] r);
    if (r == 0) return 0;
    return (r == IR[25:21]) ||
           ((IR[31:26] inside {6'd0, 6'd4, 6'd5, 6'd43}) && (r == IR[20:16]));
  endfunction

  function automatic bit lu_hit();
    return DX_MemRead && reads(DX_RD);
  endfunction

  function automatic bit raw_hit();
    if (FWD_ON) return 0;
    return (DX_RegWrite && reads(DX_RD)) || (XM_RegWrite && reads(XM_RD));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (!FWD_ON || src == 0) return 2'b00;
    if (XM_RegWrite && XM_RD == src) return 2'b10;
    if (MW_RegWrite && MW_RD == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic rand_inputs();
    logic [5:0] ops[7];
    ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd8, 6'd2};
    IR = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          16'($urandom)};
    DX_MemRead   = ($urandom_range(0, 2) == 0);
    DX_RegWrite  = ($urandom_range(0, 1) == 0);
    DX_div       = ($urandom_range(0, 23) == 0);
    DX_RD        = 5'($urandom_range(0, 3));
    DX_RS        = 5'($urandom_range(0, 3));
    DX_RT        = 5'($urandom_range(0, 3));
    XM_RegWrite  = ($urandom_range(0, 1) == 0);
    XM_RD        = 5'($urandom_range(0, 3));
    MW_RegWrite  = ($urandom_range(0, 1) == 0);
    MW_RD        = 5'($urandom_range(0, 3));
    branch_taken = ($urandom_range(0, 15) == 0);
    jump         = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int  cnt;
    bit  done;

    // ---------------- reset values, with flush-causing inputs active ----------------
    rst = 1'b0;
    clear_inputs();
    branch_taken = 1; jump = 1;
    DX_RS = 5'd3; XM_RegWrite = 1; XM_RD = 5'd3;
    #3;
    chk("rst_pc_write", PC_write, 1);
    chk("rst_ifid_write", IF_ID_write, 1);
    chk("rst_if_flush", IF_flush, 0);
    chk("rst_dx_flush", DX_flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwdA", fwdA, 0);
    do_reset();

    // ---------------- table of single-cycle vectors from RUN ----------------
    vt[0]  = '{mk_ir(6'd0, 5'd4, 5'd1), 0,0,0, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,0, 0,0, 2'b00,2'b00};
    vt[1]  = '{mk_ir(6'd0, 5'd4, 5'd1), 0,0,0, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 1,0, 1,1, 2'b00,2'b00};
    vt[2]  = '{mk_ir(6'd2, 5'd0, 5'd0), 0,0,0, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 1,0, 2'b00,2'b00};
    vt[3]  = '{mk_ir(6'd2, 5'd0, 5'd0), 0,0,1, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 0,0, 2'b00,2'b00};
    vt[4]  = '{mk_ir(6'd0, 5'd4, 5'd1), 1,1,0, 5'd4,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 0,0, 2'b00,2'b00};
    vt[5]  = '{mk_ir(6'd0, 5'd0, 5'd0), 1,0,0, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 1,0, 2'b00,2'b00};
    vt[6]  = '{mk_ir(6'd8, 5'd1, 5'd4), 1,0,0, 5'd4,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 1,0, 2'b00,2'b00};
    vt[7]  = '{mk_ir(6'd2, 5'd0, 5'd0), 0,0,1, 5'd0,5'd0,5'd0, 0,5'd0, 0,5'd0, 1,1, 1,1, 2'b00,2'b00};
    vt[8]  = '{32'h0, 0,0,0, 5'd0,5'd3,5'd7, 1,5'd3, 1,5'd3, 0,0, 0,0, 2'b10,2'b00};
    vt[9]  = '{32'h0, 0,0,0, 5'd0,5'd3,5'd7, 1,5'd0, 1,5'd3, 0,0, 0,0, 2'b01,2'b00};
    vt[10] = '{32'h0, 0,0,0, 5'd0,5'd2,5'd5, 0,5'd5, 1,5'd5, 0,0, 0,0, 2'b00,2'b01};
    vt[11] = '{32'h0, 0,0,0, 5'd0,5'd0,5'd0, 1,5'd0, 1,5'd0, 0,0, 0,0, 2'b00,2'b00};
    vt[12] = '{mk_ir(6'd43, 5'd1, 5'd4), 1,0,0, 5'd4,5'd0,5'd0, 0,5'd0, 0,5'd0, 0,1, 0,0, 2'b00,2'b00};

    for (int i = 0; i < 13; i++) begin
      do_reset();
      IR = vt[i].ir; DX_MemRead = vt[i].memrd; DX_RegWrite = vt[i].dxwr; DX_div = vt[i].div;
      DX_RD = vt[i].dxrd; DX_RS = vt[i].dxrs; DX_RT = vt[i].dxrt;
      XM_RegWrite = vt[i].xmwr; XM_RD = vt[i].xmrd; MW_RegWrite = vt[i].mwwr; MW_RD = vt[i].mwrd;
      branch_taken = vt[i].br; jump = vt[i].jmp;
      @(negedge clk);
      chk($sformatf("vec%0d_if_flush", i), IF_flush, vt[i].e_iff);
      chk($sformatf("vec%0d_dx_flush", i), DX_flush, vt[i].e_dxf);
      chk($sformatf("vec%0d_pc_write", i), PC_write, 1);
      chk($sformatf("vec%0d_fwdA", i), fwdA, FWD_ON ? vt[i].e_fa : 2'b00);
      chk($sformatf("vec%0d_fwdB", i), fwdB, FWD_ON ? vt[i].e_fb : 2'b00);
    end

    // ---------------- lw $4 ; add $5,$4,$1 ----------------
    do_reset();
    IR = mk_ir(6'd0, 5'd4, 5'd1); DX_MemRead = 1; DX_RegWrite = 1; DX_RD = 5'd4;
    @(negedge clk);
    chk("lu_detect_pc", PC_write, 1);
    chk("lu_detect_cnt", stall_cnt, 0);
    next_cycle();
    DX_MemRead = 0; DX_RegWrite = 0; DX_RD = 0;
    @(negedge clk);
    chk("lu_stall_pc", PC_write, 0);
    chk("lu_stall_ifid", IF_ID_write, 0);
    chk("lu_stall_dxf", DX_flush, 1);
    chk("lu_stall_busy", busy, 1);
    next_cycle();
    @(negedge clk);
    chk("lu_after_pc", PC_write, 1);
    chk("lu_after_busy", busy, 0);
    chk("lu_after_cnt", stall_cnt, 1);

    // ---------------- div, then reset mid load-use stall ----------------
    do_reset();
    DX_div = 1; jump = 1;
    @(negedge clk);
    chk("div_entry_pc", PC_write, 1);
    chk("div_entry_iff", IF_flush, 0);
    next_cycle();
    DX_div = 0;
    cnt = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        cnt++;
        chk("div_pc_low", PC_write, 0);
        chk("div_dx_hold", DX_flush, 0);
        chk("div_jump_ignored", IF_flush, 0);
        next_cycle();
      end else begin
        done = 1;
      end
    end
    chk("div_exit_seen", done, 1);
    chk("div_busy_cycles", cnt, DLAT - 1);
    chk("div_stall_cnt", stall_cnt, DLAT - 1);
    chk("div_exit_iff", IF_flush, 1);
    next_cycle();
    jump = 0;
    IR = mk_ir(6'd0, 5'd4, 5'd1); DX_MemRead = 1; DX_RegWrite = 1; DX_RD = 5'd4;
    next_cycle();
    DX_MemRead = 0; DX_RegWrite = 0; DX_RD = 0;
    @(negedge clk);
    chk("lu2_stall_pc", PC_write, 0);
    chk("lu2_stall_cnt", stall_cnt, DLAT - 1);
    branch_taken = 1;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pc", PC_write, 1);
    chk("async_rst_dxf", DX_flush, 0);
    chk("async_rst_iff", IF_flush, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    branch_taken = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pc", PC_write, 1);

    // ---------------- branch on 3rd DIV_BUSY cycle ----------------
    do_reset();
    DX_div = 1;
    next_cycle();
    DX_div = 0;
    next_cycle();
    next_cycle();
    branch_taken = 1;
    @(negedge clk);
    chk("br_div_busy", busy, 1);
    chk("br_div_iff", IF_flush, 1);
    chk("br_div_dxf", DX_flush, 1);
    chk("br_div_pc", PC_write, 1);
    chk("br_div_cnt", stall_cnt, 2);
    next_cycle();
    branch_taken = 0;
    @(negedge clk);
    chk("br_div_run", busy, 0);
    chk("br_div_run_pc", PC_write, 1);

    // ---------------- add $6,$2,$1 ; sub $7,$6,$1 ----------------
    do_reset();
    IR = mk_ir(6'd0, 5'd6, 5'd1); DX_RegWrite = 1; DX_RD = 5'd6;
    @(negedge clk);
    chk("raw_detect_pc", PC_write, 1);
    next_cycle();
    DX_RegWrite = 0; DX_RD = 0; XM_RegWrite = 1; XM_RD = 5'd6;
    @(negedge clk);
    chk("raw_c1_pc", PC_write, FWD_ON ? 1'b1 : 1'b0);
    chk("raw_c1_dxf", DX_flush, FWD_ON ? 1'b0 : 1'b1);
    chk("raw_c1_fwdA", fwdA, 2'b00);
    next_cycle();
    XM_RegWrite = 0; XM_RD = 0; MW_RegWrite = 1; MW_RD = 5'd6;
    @(negedge clk);
    chk("raw_c2_pc", PC_write, FWD_ON ? 1'b1 : 1'b0);
    next_cycle();
    MW_RegWrite = 0; MW_RD = 0;
    @(negedge clk);
    chk("raw_done_pc", PC_write, 1);
    chk("raw_done_busy", busy, 0);
    chk("raw_stall_cnt", stall_cnt, FWD_ON ? 0 : 2);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_div_left = 0; m_lu = 0; m_raw = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      bit idle, e_pc, e_dxf, e_iff, lh, rh;
      rand_inputs();
      lh    = lu_hit();
      rh    = raw_hit();
      idle  = (m_div_left == 0) && !m_lu && !m_raw;
      e_pc  = idle || branch_taken;
      e_dxf = branch_taken || m_lu || m_raw;
      e_iff = branch_taken || (idle && jump && !DX_div && !lh && !rh);
      @(negedge clk);
      chk("rnd_pc_write", PC_write, e_pc);
      chk("rnd_ifid_write", IF_ID_write, e_pc);
      chk("rnd_if_flush", IF_flush, e_iff);
      chk("rnd_dx_flush", DX_flush, e_dxf);
      chk("rnd_busy", busy, !idle);
      chk("rnd_stall_cnt", stall_cnt, m_stall);
      chk("rnd_fwdA", fwdA, exp_fwd(DX_RS));
      chk("rnd_fwdB", fwdB, exp_fwd(DX_RT));
      if (!e_pc) m_stall++;
      if (branch_taken) begin
        m_div_left = 0; m_lu = 0; m_raw = 0;
      end else if (m_div_left > 0) m_div_left--;
      else if (m_lu) m_lu = 0;
      else if (m_raw) m_raw = rh;
      else if (DX_div) m_div_left = DLAT - 1;
      else if (lh) m_lu = 1;
      else if (rh) m_raw = 1;
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
